// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB requester: FSM state encoding and
// the register map of the I2C bridge completer it talks to.
package apb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } apb_state_e;

    localparam logic [31:0] ADDR_TX_FIFO = 32'd0;
    localparam logic [31:0] ADDR_RX_FIFO = 32'd4;
    localparam logic [31:0] ADDR_CONFIG  = 32'd8;
    localparam logic [31:0] ADDR_TIMEOUT = 32'd12;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter; expired_o flags that the current ACCESS
// cycle is the LIMIT-th one. LIMIT = 0 never expires.
module apb_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (int'(cnt_q) < LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q counts completed low-PREADY cycles, so the current one is cnt_q+1.
    assign expired_o = (LIMIT > 0) && ((int'(cnt_q) + 1) >= LIMIT);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB requester: turns a valid/ready command stream into
// SETUP/ACCESS transfers with a bounded wait-state timeout.
module apb_master
    import apb_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_WRITE,
    input  logic [31:0] CMD_ADDR,
    input  logic [31:0] CMD_WDATA,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic        RSP_TIMEOUT,
    output logic        PSELx,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    apb_state_e  state_q, state_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        tmo_q, tmo_d;
    logic        tmr_clr, tmr_en, tmr_expired;

    apb_wait_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i    (PCLK),
        .rst_i    (PRESET),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .expired_o(tmr_expired)
    );

    always_comb begin
        state_d  = state_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        tmo_d    = tmo_q;
        tmr_clr  = 1'b0;
        tmr_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    pwrite_d = CMD_WRITE;
                    paddr_d  = CMD_ADDR;
                    pwdata_d = CMD_WDATA;
                    tmr_clr  = 1'b1;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // A ready completer wins even in the last allowed cycle.
                if (PREADY) begin
                    rdata_d = pwrite_q ? 32'd0 : PRDATA;
                    err_d   = PSLVERR;
                    tmo_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (tmr_expired) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_RESP: begin
                if (RSP_READY) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= ST_IDLE;
            pwrite_q <= 1'b0;
            paddr_q  <= 32'd0;
            pwdata_q <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
        end
    end

    // Bus strobes decode straight from state so reset drops them immediately.
    assign CMD_READY   = (state_q == ST_IDLE);
    assign PSELx       = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign PENABLE     = (state_q == ST_ACCESS);
    assign RSP_VALID   = (state_q == ST_RESP);
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign RSP_RDATA   = rdata_q;
    assign RSP_ERR     = err_q;
    assign RSP_TIMEOUT = tmo_q;

endmodule

// File: tb/tb_apb_master.sv
// Randomized bench for apb_master: a transaction-level model predicts latency
// and response fields from the wait-state count and completer status.
module tb_apb_master;
    import apb_master_pkg::*;

    localparam int TMO = 4;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        CMD_VALID, CMD_READY, CMD_WRITE;
    logic [31:0] CMD_ADDR, CMD_WDATA;
    logic        RSP_VALID, RSP_READY;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR, RSP_TIMEOUT;
    logic        PSELx, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR;

    int n_checks = 0;
    int n_errors = 0;

    apb_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
        .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT),
        .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // One command from acceptance to response hand-off. nwait is the number of
    // ACCESS cycles with PREADY low before the completer would answer.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int nwait, input logic [31:0] rd, input logic serr,
                           input int hold);
        logic        tmo;
        int          lat;
        int          cyc;
        int          a;
        logic [31:0] exp_rd;
        logic        exp_err;
        tmo     = (TMO != 0) && (nwait >= TMO);
        lat     = tmo ? 2 + TMO : 3 + nwait;
        exp_rd  = (wr || tmo) ? 32'd0 : rd;
        exp_err = tmo ? 1'b1 : serr;

        check("idle_cmd_ready", {31'd0, CMD_READY}, 32'd1);
        check("idle_psel", {31'd0, PSELx}, 32'd0);
        CMD_VALID = 1'b1;
        CMD_WRITE = wr;
        CMD_ADDR  = addr;
        CMD_WDATA = wdata;
        RSP_READY = 1'($urandom);
        tick();
        cyc = 1;
        while (!RSP_VALID && cyc < lat + 4) begin
            check("busy_psel", {31'd0, PSELx}, 32'd1);
            check("busy_penable", {31'd0, PENABLE}, (cyc >= 2) ? 32'd1 : 32'd0);
            check("busy_cmd_ready", {31'd0, CMD_READY}, 32'd0);
            check("busy_paddr", PADDR, addr);
            check("busy_pwrite", {31'd0, PWRITE}, {31'd0, wr});
            check("busy_pwdata", PWDATA, wdata);
            // A command offered while busy must be ignored.
            CMD_VALID = 1'b1;
            CMD_WRITE = 1'($urandom);
            CMD_ADDR  = $urandom;
            CMD_WDATA = $urandom;
            a = cyc - 2;
            if (a >= 0) begin
                PREADY  = (a == nwait);
                PRDATA  = PREADY ? rd : $urandom;
                PSLVERR = PREADY ? serr : 1'($urandom);
            end else begin
                PREADY  = 1'($urandom);
                PRDATA  = $urandom;
                PSLVERR = 1'($urandom);
            end
            tick();
            cyc++;
        end
        check("latency", cyc, lat);
        CMD_VALID = 1'b0;
        PREADY    = 1'($urandom);
        PRDATA    = $urandom;
        PSLVERR   = 1'($urandom);
        for (int h = 0; h <= hold; h++) begin
            check("rsp_valid", {31'd0, RSP_VALID}, 32'd1);
            check("rsp_psel", {30'd0, PSELx, PENABLE}, 32'd0);
            check("rsp_cmd_ready", {31'd0, CMD_READY}, 32'd0);
            check("rsp_rdata", RSP_RDATA, exp_rd);
            check("rsp_err", {31'd0, RSP_ERR}, {31'd0, exp_err});
            check("rsp_timeout", {31'd0, RSP_TIMEOUT}, {31'd0, tmo});
            check("rsp_paddr_hold", PADDR, addr);
            RSP_READY = (h == hold);
            tick();
        end
        RSP_READY = 1'b0;
        check("post_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
    endtask

    initial begin
        PRESET = 1'b1;
        CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = 32'd0; CMD_WDATA = 32'd0;
        RSP_READY = 1'b0; PRDATA = 32'd0; PREADY = 1'b0; PSLVERR = 1'b0;
        #12;
        check("rst_psel", {30'd0, PSELx, PENABLE}, 32'd0);
        check("rst_pwrite", {31'd0, PWRITE}, 32'd0);
        check("rst_paddr", PADDR, 32'd0);
        check("rst_pwdata", PWDATA, 32'd0);
        check("rst_rsp", {29'd0, RSP_VALID, RSP_ERR, RSP_TIMEOUT}, 32'd0);
        check("rst_rdata", RSP_RDATA, 32'd0);
        check("rst_cmd_ready", {31'd0, CMD_READY}, 32'd1);
        tick();
        PRESET = 1'b0;
        tick();

        run_txn(1'b1, ADDR_CONFIG, 32'h0000_00A5, 0, 32'hDEAD_BEEF, 1'b0, 0);
        run_txn(1'b0, ADDR_RX_FIFO, 32'h1111_2222, 2, 32'hA5A5_0001, 1'b0, 0);
        run_txn(1'b1, ADDR_TX_FIFO, 32'h0000_005A, 0, 32'h0BAD_0BAD, 1'b1, 0);
        run_txn(1'b0, ADDR_TIMEOUT, 32'h0, TMO, 32'hFFFF_FFFF, 1'b0, 0);
        run_txn(1'b0, ADDR_RX_FIFO, 32'h0, TMO - 1, 32'h1234_5678, 1'b1, 0);
        run_txn(1'b1, ADDR_CONFIG, 32'h0000_0077, 1, 32'h0, 1'b0, 5);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] addr;
            addr = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3)) << 2;
            run_txn(1'($urandom), addr, $urandom, $urandom_range(0, TMO + 1),
                    $urandom, 1'($urandom), $urandom_range(0, 3));
        end

        // Reset in the middle of a write's ACCESS phase.
        CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = ADDR_CONFIG; CMD_WDATA = 32'h55;
        tick();
        CMD_VALID = 1'b0;
        PREADY    = 1'b0;
        tick();
        check("mid_penable", {31'd0, PENABLE}, 32'd1);
        #2;
        PRESET = 1'b1;
        #1;
        check("async_psel", {31'd0, PSELx}, 32'd0);
        check("async_penable", {31'd0, PENABLE}, 32'd0);
        check("async_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
        tick();
        PRESET  = 1'b0;
        PREADY  = 1'b1;
        PSLVERR = 1'b1;
        check("after_rst_paddr", PADDR, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("after_rst_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
            check("after_rst_cmd_ready", {31'd0, CMD_READY}, 32'd1);
            check("after_rst_psel", {31'd0, PSELx}, 32'd0);
        end
        run_txn(1'b0, ADDR_RX_FIFO, 32'h0, 0, 32'hCAFE_F00D, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
